input_debouncer: RTL and testbench



---
 rtl/input_debouncer_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/input_debouncer.sv | 137 +++++++++++++
 tb/tb_input_debouncer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// ============================================================================
// Module   : input_debouncer_pkg
// Brief    : Shared FSM state type and default parameters for input_debouncer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } deb_state_t;

    localparam int unsigned c_def_stable_cycles = 1000;
    localparam int unsigned c_def_cnt_w         = 10;
    localparam logic        c_def_rst_val       = 1'b0;

endpackage : input_debouncer_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchroniser for an asynchronous single-bit input, with
//            asynchronous active-low reset to a parameterised level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_ff1;
    logic r_ff2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff1 <= RST_VAL;
            r_ff2 <= RST_VAL;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/input_debouncer.sv
// ============================================================================
// Module   : input_debouncer
// Brief    : Synchronises and debounces a raw pin into a registered stable
//            level; INPUT_DEBOUNCER_EDGE_EN adds rise/fall one-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = c_def_stable_cycles,
    parameter int unsigned CNT_W         = c_def_cnt_w,
    parameter logic        RST_VAL       = c_def_rst_val
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic d_o,
    output logic busy_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] c_cnt_max   = CNT_W'(STABLE_CYCLES - 1);
    localparam deb_state_t       c_rst_state = RST_VAL ? IDLE_HI : IDLE_LO;

    logic             w_sync_q;
    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_d;
    logic             w_d_nxt;

    sync_2ff #(
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (raw_i),
        .o_q   (w_sync_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_rst_state;
            r_cnt   <= '0;
            r_d     <= RST_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_d     <= w_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_d_nxt     = r_d;
        case (r_state)
            IDLE_LO: begin
                if (w_sync_q) begin
                    w_state_nxt = CHK_HI;
                    w_cnt_nxt   = '0;
                end
            end
            CHK_HI: begin
                if (!w_sync_q) begin
                    w_state_nxt = IDLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_nxt = IDLE_HI;
                    w_cnt_nxt   = '0;
                    w_d_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!w_sync_q) begin
                    w_state_nxt = CHK_LO;
                    w_cnt_nxt   = '0;
                end
            end
            CHK_LO: begin
                if (w_sync_q) begin
                    w_state_nxt = IDLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_nxt = IDLE_LO;
                    w_cnt_nxt   = '0;
                    w_d_nxt     = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_rst_state;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign d_o    = r_d;
    assign busy_o = (r_state == CHK_HI) || (r_state == CHK_LO);

`ifdef INPUT_DEBOUNCER_EDGE_EN
    logic w_rise_acc;
    logic w_fall_acc;
    logic r_rise;
    logic r_fall;

    // Acceptance terms mirror the terminal-count branches of the FSM above.
    assign w_rise_acc = (r_state == CHK_HI) && w_sync_q  && (r_cnt == c_cnt_max);
    assign w_fall_acc = (r_state == CHK_LO) && !w_sync_q && (r_cnt == c_cnt_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_rise_acc;
            r_fall <= w_fall_acc;
        end
    end

    assign rise_o = r_rise;
    assign fall_o = r_fall;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule : input_debouncer

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// ============================================================================
// Module   : tb_input_debouncer
// Brief    : Scoreboard bench for input_debouncer (STABLE_CYCLES=4, CNT_W=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debouncer;

    localparam int unsigned c_stable = 4;
    localparam int unsigned c_cnt_w  = 3;
`ifdef INPUT_DEBOUNCER_EDGE_EN
    localparam logic c_pe = 1'b1;
`else
    localparam logic c_pe = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  exp;
        logic [31:0] id;
    } sb_entry_t;

    logic clk;
    logic rst_n;
    logic raw_i;
    logic d_o;
    logic busy_o;
    logic rise_o;
    logic fall_o;

    int        n_checks;
    int        n_errors;
    int        step_no;
    string     scen;
    sb_entry_t exp_q[$];

    input_debouncer #(
        .STABLE_CYCLES (c_stable),
        .CNT_W         (c_cnt_w),
        .RST_VAL       (1'b0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (raw_i),
        .d_o    (d_o),
        .busy_o (busy_o),
        .rise_o (rise_o),
        .fall_o (fall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive raw_i at the falling edge; expectation covers the next rising edge.
    // Expected vector order is {d, busy, rise, fall}; pulses are 0 without the edge build.
    task automatic step(input logic raw, input logic [3:0] exp);
        sb_entry_t e;
        @(negedge clk);
        raw_i  = raw;
        e.exp  = exp & {2'b11, c_pe, c_pe};
        e.id   = 32'(step_no);
        step_no++;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {d_o, busy_o, rise_o, fall_o};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: d/busy/rise/fall got %b expected %b", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        sb_entry_t e;
        logic [3:0] act;
        #2;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {d_o, busy_o, rise_o, fall_o};
            n_checks++;
            if (act !== e.exp) begin
                n_errors++;
                $display("FAIL %s step%0d: d/busy/rise/fall got %b expected %b",
                         scen, e.id, act, e.exp);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        step_no  = 0;
        scen     = "reset";
        rst_n    = 1'b0;
        raw_i    = 1'b0;
        repeat (2) @(negedge clk);
        check_now("reset_state", 4'b0000);
        rst_n = 1'b1;

        scen = "clean_rise";
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0100);
        step(1'b1, 4'b0100);
        step(1'b1, 4'b0100);
        step(1'b1, 4'b0100);
        step(1'b1, 4'b1010);
        step(1'b1, 4'b1000);
        step(1'b1, 4'b1000);

        scen = "clean_fall";
        step(1'b0, 4'b1000);
        step(1'b0, 4'b1000);
        step(1'b0, 4'b1100);
        step(1'b0, 4'b1100);
        step(1'b0, 4'b1100);
        step(1'b0, 4'b1100);
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0000);

        scen = "bounce";
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);

        // Reach CHK_HI with cnt=2, then abort with an asynchronous reset.
        scen = "reset_mid_check";
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0100);
        step(1'b1, 4'b0100);
        step(1'b1, 4'b0100);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_now("async_reset_in_chk", 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check_now("held_reset", 4'b0000);
        #2;
        rst_n = 1'b1;
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0100);
        step(1'b1, 4'b0100);
        step(1'b1, 4'b0100);
        step(1'b1, 4'b0100);
        step(1'b1, 4'b1010);
        step(1'b1, 4'b1000);

        // d_o is high here with raw_i still high; reset must clear it without a clock.
        scen = "async_reset_high";
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_now("async_reset_d_high", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        raw_i = 1'b0;
        repeat (3) @(posedge clk);
        #3;

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: pending %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_input_debouncer

`default_nettype wire
